// File: rtl/mlp_sched_pkg.sv
// rtl/mlp_sched_pkg.sv - shared state encoding and constants for the MLP batch scheduler
package mlp_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RECORD,
    S_DONE
  } state_t;

  // ISSUE and RECORD add two cycles on top of the MLP latency for every case
  localparam int unsigned CASE_OVERHEAD = 2;

endpackage

// File: rtl/mlp_watchdog.sv
// rtl/mlp_watchdog.sv - per-case watchdog: clearable enabled counter flagging timeout_cycles-1
module mlp_watchdog #(
  parameter int timeout_cycles = 4096,
  parameter int clog2_timeout  = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam logic [clog2_timeout-1:0] limit = clog2_timeout'(timeout_cycles - 1);

  logic [clog2_timeout-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clk_en) begin
      if (clear) count <= '0;
      else if (inc) count <= count + 1'b1;
    end
  end

  assign expired = (count == limit);

endmodule

// File: rtl/mlp_batch_scheduler.sv
// rtl/mlp_batch_scheduler.sv - sequences the MLP over a batch of stored cases and scores the labels
module mlp_batch_scheduler
  import mlp_sched_pkg::*;
#(
  parameter int clog2_size_of_output_layer = 4,
  parameter int number_of_test_cases       = 750,
  parameter int clog2_number_of_test_cases = 10,
  parameter int timeout_cycles             = 4096,
  parameter int clog2_timeout              = 12
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clk_en,
  input  logic                                  start,
  input  logic                                  abort,
  output logic                                  mlp_start,
  input  logic                                  mlp_ready,
  input  logic [clog2_size_of_output_layer-1:0] mlp_label,
  input  logic [clog2_size_of_output_layer-1:0] expected_label,
  output logic [clog2_number_of_test_cases-1:0] case_index,
  output logic [clog2_size_of_output_layer-1:0] last_label,
  output logic                                  last_valid,
  output logic [clog2_number_of_test_cases:0]   correct_count,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  timeout_err
);

  localparam logic [clog2_number_of_test_cases-1:0] last_index =
    clog2_number_of_test_cases'(number_of_test_cases - 1);

  state_t state;
  logic   launch;
  logic   wd_clear;
  logic   wd_inc;
  logic   wd_expired;

  assign launch     = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign mlp_start  = (state == S_ISSUE) && clk_en;
  // an aborted RECORD is neither scored nor announced
  assign last_valid = (state == S_RECORD) && clk_en && !abort;
  assign wd_clear   = launch || ((state == S_RECORD) && !abort && (case_index != last_index));
  assign wd_inc     = (state == S_WAIT) && !abort && !mlp_ready && !wd_expired;

  mlp_watchdog #(
    .timeout_cycles(timeout_cycles),
    .clog2_timeout (clog2_timeout)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .clear  (wd_clear),
    .inc    (wd_inc),
    .expired(wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      case_index    <= '0;
      correct_count <= '0;
      last_label    <= '0;
      timeout_err   <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else if (clk_en) begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state         <= S_ISSUE;
            case_index    <= '0;
            correct_count <= '0;
            timeout_err   <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (mlp_ready) begin
            state      <= S_RECORD;
            last_label <= mlp_label;
          end else if (wd_expired) begin
            state       <= S_DONE;
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end
        S_RECORD: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            if (last_label == expected_label) correct_count <= correct_count + 1'b1;
            if (case_index == last_index) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              case_index <= case_index + 1'b1;
              state      <= S_ISSUE;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mlp_batch_scheduler.md
# mlp_batch_scheduler

Sequencer that runs the MLP inference datapath over a batch of stored test cases. It issues one start pulse per case and waits for the datapath's `ready` under a watchdog. It then scores the returned label against the expected label and advances the case index that addresses the data and label memories. It sits between the test-case memories and the `MLP` instance and replaces free-running index counting with an explicit handshake.

## Interface
- `clog2_size_of_output_layer`, 4: label width.
- `number_of_test_cases`, 750: cases per batch (N), N ≥ 1.
- `clog2_number_of_test_cases`, 10: index width, 2^W ≥ N.
- `timeout_cycles`, 4096: watchdog limit per case, ≥ 2.
- `clog2_timeout`, 12: watchdog width, 2^W ≥ timeout_cycles.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `clk_en`  in  1  global enable; when low, all state, counters and outputs hold.
- `start`  in  1  begins a batch; honoured only in IDLE or DONE.
- `abort`  in  1  cancels a running batch.
- `mlp_start`  out  1  one-cycle start pulse to the MLP.
- `mlp_ready`  in  1  MLP result valid (level).
- `mlp_label`  in  clog2_size_of_output_layer  MLP result.
- `expected_label`  in  clog2_size_of_output_layer  golden label at `case_index` (combinational ROM read).
- `case_index`  out  clog2_number_of_test_cases  current case address.
- `last_label`  out  clog2_size_of_output_layer  most recent recorded label.
- `last_valid`  out  1  one-cycle pulse when `last_label` updates.
- `correct_count`  out  clog2_number_of_test_cases+1  matches in current batch.
- `busy`  out  1  high in ISSUE, WAIT and RECORD.
- `done`  out  1  high in DONE.
- `timeout_err`  out  1  sticky; set on watchdog expiry.

## Operation
- States: IDLE, ISSUE, WAIT, RECORD, DONE. All transitions are qualified by `clk_en`.
- IDLE/DONE + `start` → ISSUE. Clears `case_index`, `correct_count`, `timeout_err` and the watchdog.
- ISSUE → WAIT unconditionally. `mlp_start = (state==ISSUE) & clk_en`.
- WAIT:
  - `mlp_ready` is sampled only here. The MLP drops `ready` no later than the cycle after `mlp_start`, so stale `ready` is never seen.
  - `mlp_ready` → RECORD. Captures `mlp_label` into `last_label`.
  - Otherwise the watchdog increments. If the watchdog equals `timeout_cycles-1` and `mlp_ready` is still low → DONE with `timeout_err=1`.
- RECORD:
  - Pulses `last_valid`.
  - If `last_label == expected_label`, increments `correct_count`.
  - If `case_index == N-1` → DONE. Otherwise increments `case_index`, clears the watchdog, → ISSUE.
- `abort` in ISSUE/WAIT/RECORD → IDLE. Counts and `case_index` hold their values; the RECORD of that cycle is not scored. `abort` in IDLE/DONE is ignored.
- `abort` and `start` together: `abort` wins in busy states; `start` wins in IDLE/DONE.
- `case_index` never wraps. It saturates at N-1; `correct_count` ≤ N.

## Timing
- Reset values: state IDLE, `case_index` 0, `correct_count` 0, `last_label` 0, `last_valid` 0, `mlp_start` 0, `busy` 0, `done` 0, `timeout_err` 0.
- `rst` overrides `clk_en`, `start` and `abort`, and takes effect mid-batch on the next edge.
- `start` sampled at edge k → `mlp_start` high in cycle k+1.
- MLP latency of L cycles (measured from `mlp_start` to `ready`) → RECORD occurs L+1 cycles after ISSUE. Per-case period is L+2 cycles; batch length is N·(L+2)+1 cycles from `start` to `done`.
- `expected_label` must be valid in the same cycle as RECORD; `case_index` is stable from ISSUE through RECORD.
- With `clk_en` low, `mlp_start` and `last_valid` are forced low, and the cycle does not count toward the watchdog.

## Structure
- Package `mlp_sched_pkg`: state enum encoding and the per-case overhead constant (2).
- Sub-module `mlp_watchdog`: clearable, enabled counter with an `expired` flag at `timeout_cycles-1`. All other logic stays in one FSM module.

## Test plan
- N=4, MLP model with L=3, all labels match: `start` → exactly 4 `mlp_start` pulses 5 cycles apart; `done` at cycle 21; `correct_count=4`; `case_index=3`.
- N=4, case 2 mismatches (`mlp_label=7`, `expected_label=3`) → `correct_count=3`; `last_label` sequence matches the model.
- `timeout_cycles=8`, MLP never asserts `ready` on case 1 → `done` with `timeout_err=1`, `case_index=1`, `correct_count=1`, no further `mlp_start`.
- `abort` during WAIT of case 2 → IDLE next edge, `busy=0`, `correct_count=2` held. A new `start` restarts from index 0 with the count cleared.
- `clk_en` toggled 50% during a batch → identical final counts; no pulse longer than one enabled cycle; batch time doubles.
- `rst` asserted in RECORD with `clk_en=0` → all outputs at reset values after one edge.
